// File: rtl/btn_conditioner.sv
// Pushbutton front end: 2-flop synchroniser, counter-based debounce FSM, press/release
// strobes and a valid/ready press event. Define BTN_COND_LONG_PRESS_EN for long-press detection.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  input  logic evt_ready,
  input  logic overrun_clr,
  output logic level_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic evt_valid,
  output logic overrun,
  output logic long_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_params
    $error("btn_conditioner: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, press_nxt, release_nxt;
  logic             sync_q, btn_s;
  logic             overrun_set;

  // Pad synchroniser; btn_s is the only consumer of btn_in
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_q <= btn_in;
      btn_s  <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_LOW;
      cnt           <= '0;
      level_out     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      level_out     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  // Any sample disagreeing with the candidate level drops the count entirely
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = level_out;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      S_LOW: begin
        if (btn_s) begin
          state_nxt = S_RISE;
          cnt_nxt   = '0;
        end
      end
      S_RISE: begin
        if (!btn_s) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!btn_s) begin
          state_nxt = S_FALL;
          cnt_nxt   = '0;
        end
      end
      S_FALL: begin
        if (btn_s) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt   = S_LOW;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The press event is loaded on the same edge that raises press_pulse
  assign overrun_set = press_nxt && evt_valid && !evt_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      evt_valid <= press_nxt || (evt_valid && !evt_ready);
      overrun   <= overrun_set || (overrun && !overrun_clr);
    end
  end

`ifdef BTN_COND_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              long_done, long_fire, hold_clr;

  // Hold time is frozen (not lost) while a release is being qualified
  always_comb begin
    hold_clr  = (state == S_LOW) || (state == S_RISE);
    long_fire = (hold_cnt == HOLD_MAX) && !long_done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt   <= '0;
      long_done  <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= long_fire;
      if (hold_clr) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else begin
        if (state == S_HIGH && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
        if (long_fire) long_done <= 1'b1;
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule
